// File: rtl/apb_master_ctrl_if.sv
// Command, response and APB bus signals shared by apb_master_ctrl and whatever sits around it.
// The master modport is the controller's view; the slave modport is the surrounding environment.
interface apb_master_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    // command channel from the bridge core
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [3:0]            cmd_strb;
    logic [2:0]            cmd_prot;

    // response channel back to the bridge core
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    // APB side, two slaves sharing address/data/control
    logic                  PSEL_S0;
    logic                  PSEL_S1;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [2:0]            PPROT;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [3:0]            PSTRB;
    logic [DATA_WIDTH-1:0] PRDATA_S0;
    logic [DATA_WIDTH-1:0] PRDATA_S1;
    logic                  PREADY_S0;
    logic                  PREADY_S1;
    logic                  PSLVERR_S0;
    logic                  PSLVERR_S1;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output PSEL_S0, PSEL_S1, PENABLE, PWRITE, PPROT, PADDR, PWDATA, PSTRB,
        input  PRDATA_S0, PRDATA_S1, PREADY_S0, PREADY_S1, PSLVERR_S0, PSLVERR_S1
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  PSEL_S0, PSEL_S1, PENABLE, PWRITE, PPROT, PADDR, PWDATA, PSTRB,
        output PRDATA_S0, PRDATA_S1, PREADY_S0, PREADY_S1, PSLVERR_S0, PSLVERR_S1
    );
endinterface

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: single-outstanding APB requester. Takes one command, decodes it to one of
// two slaves, runs SETUP/ACCESS with a bounded wait on PREADY and hands back data/error status.
module apb_master_ctrl #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] A_START_SLAVE0 = ADDR_WIDTH'(32'h0000_1000),
    parameter logic [ADDR_WIDTH-1:0] A_END_SLAVE0   = ADDR_WIDTH'(32'h0000_1FFF),
    parameter logic [ADDR_WIDTH-1:0] A_START_SLAVE1 = ADDR_WIDTH'(32'h0000_2000),
    parameter logic [ADDR_WIDTH-1:0] A_END_SLAVE1   = ADDR_WIDTH'(32'h0000_2FFF),
    parameter int                    TIMEOUT_CYCLES = 16
) (
    input logic               PCLK,
    input logic               PRESET,
    apb_master_ctrl_if.master bus
);
    // The counter only has to reach TIMEOUT_CYCLES-2: the ACCESS cycle that sees that value
    // with PREADY still low is the last one allowed.
    localparam int             CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state;
    state_t                state_next;
    logic                  take_cmd;
    logic                  decode_miss;
    logic                  slave_done;
    logic                  timed_out;
    logic                  hit_s0;
    logic                  hit_s1;
    logic                  sel_s1_q;
    logic [CNT_W-1:0]      tmo_count;
    logic                  sel_pready;
    logic                  sel_pslverr;
    logic [DATA_WIDTH-1:0] sel_prdata;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [3:0]            pstrb_q;
    logic [2:0]            pprot_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;

    // Inclusive address windows; slave 0 takes priority should the windows ever overlap.
    assign hit_s0 = (bus.cmd_addr >= A_START_SLAVE0) && (bus.cmd_addr <= A_END_SLAVE0);
    assign hit_s1 = (bus.cmd_addr >= A_START_SLAVE1) && (bus.cmd_addr <= A_END_SLAVE1);

    // Only the selected slave's return signals are looked at.
    assign sel_pready  = sel_s1_q ? bus.PREADY_S1  : bus.PREADY_S0;
    assign sel_pslverr = sel_s1_q ? bus.PSLVERR_S1 : bus.PSLVERR_S0;
    assign sel_prdata  = sel_s1_q ? bus.PRDATA_S1  : bus.PRDATA_S0;

    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.PSEL_S0   = ((state == SETUP) || (state == ACCESS)) && !sel_s1_q;
    assign bus.PSEL_S1   = ((state == SETUP) || (state == ACCESS)) && sel_s1_q;
    assign bus.PENABLE   = (state == ACCESS);
    assign bus.PWRITE    = pwrite_q;
    assign bus.PPROT     = pprot_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PSTRB     = pstrb_q;

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the one-cycle events that steer the datapath registers.
    always_comb begin
        state_next  = state;
        take_cmd    = 1'b0;
        decode_miss = 1'b0;
        slave_done  = 1'b0;
        timed_out   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    take_cmd = 1'b1;
                    if (hit_s0 || hit_s1) begin
                        state_next = SETUP;
                    end else begin
                        decode_miss = 1'b1;
                        state_next  = RESP;
                    end
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (sel_pready) begin
                    slave_done = 1'b1;
                    state_next = RESP;
                end else if (tmo_count == CNT_LAST) begin
                    timed_out  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Wait-state counter: runs while ACCESS continues, cleared whenever ACCESS is left.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tmo_count <= '0;
        end else if ((state == ACCESS) && (state_next == ACCESS)) begin
            tmo_count <= tmo_count + 1'b1;
        end else begin
            tmo_count <= '0;
        end
    end

    // Command capture into the APB drive registers and response capture at the end of a transfer.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            pwrite_q    <= 1'b0;
            sel_s1_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (take_cmd) begin
                paddr_q  <= bus.cmd_addr;
                pwdata_q <= bus.cmd_wdata;
                pprot_q  <= bus.cmd_prot;
                pwrite_q <= bus.cmd_write;
                pstrb_q  <= bus.cmd_write ? bus.cmd_strb : 4'b0000;
                sel_s1_q <= !hit_s0 && hit_s1;
            end
            if (decode_miss || timed_out) begin
                rsp_err_q   <= 1'b1;
                rsp_rdata_q <= '0;
            end else if (slave_done) begin
                rsp_err_q   <= sel_pslverr;
                rsp_rdata_q <= pwrite_q ? '0 : sel_prdata;
            end
        end
    end
endmodule

// File: tb/tb_apb_master_ctrl.sv
// Testbench for apb_master_ctrl: acts as bridge core and both APB slaves, and compares what
// it sees against expectations derived from address windows, wait counts and the timeout limit.
module tb_apb_master_ctrl;
    localparam int TIMEOUT = 16;

    logic PCLK = 1'b0;
    logic PRESET;
    int   checks = 0;
    int   errors = 0;

    // observations collected by do_txn for the calling test to judge
    bit          obs_seen;
    bit          obs_ready_at_issue;
    bit          obs_release_ok;
    int          obs_rsp_cycle;
    int          obs_psel0;
    int          obs_psel1;
    int          obs_penable;
    int          obs_apb_bad;
    int          obs_hold_bad;
    logic        obs_err;
    logic [31:0] obs_rdata;

    apb_master_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_master_ctrl #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .A_START_SLAVE0(32'h0000_1000), .A_END_SLAVE0(32'h0000_1FFF),
        .A_START_SLAVE1(32'h0000_2000), .A_END_SLAVE1(32'h0000_2FFF),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .PCLK(PCLK),
        .PRESET(PRESET),
        .bus(bus)
    );

    // free-running clock
    always #5 PCLK = ~PCLK;

    // bus-wide invariants checked every cycle outside reset
    always @(negedge PCLK) begin
        if (PRESET === 1'b0) begin
            checks++;
            if ((bus.PSEL_S0 && bus.PSEL_S1) || (bus.PENABLE && !(bus.PSEL_S0 || bus.PSEL_S1))) begin
                errors++;
                $display("[TB] FAIL psel_invariant: PSEL_S0=%b PSEL_S1=%b PENABLE=%b, required at most one PSEL and PENABLE only with PSEL", bus.PSEL_S0, bus.PSEL_S1, bus.PENABLE);
            end
        end
    end

    // hard stop in case something hangs outside a bounded loop
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // reference decode: 0 = slave 0, 1 = slave 1, 2 = no slave
    function automatic int decode(input logic [31:0] a);
        if (a >= 32'h1000 && a <= 32'h1FFF) return 0;
        if (a >= 32'h2000 && a <= 32'h2FFF) return 1;
        return 2;
    endfunction

    // waits < 0 means the slave never becomes ready
    function automatic bit times_out(input int waits);
        return (waits < 0) || (waits > TIMEOUT - 2);
    endfunction

    function automatic int access_cycles(input int waits);
        return times_out(waits) ? TIMEOUT - 1 : waits + 1;
    endfunction

    // Drive both slaves: the target gets the scripted response, the other gets noise.
    task automatic set_slaves(input int target, input logic ready, input logic err, input logic [31:0] data);
        bus.PREADY_S0  = 1'($urandom);
        bus.PREADY_S1  = 1'($urandom);
        bus.PSLVERR_S0 = 1'($urandom);
        bus.PSLVERR_S1 = 1'($urandom);
        bus.PRDATA_S0  = $urandom;
        bus.PRDATA_S1  = $urandom;
        if (target == 0) begin
            bus.PREADY_S0 = ready;
            if (ready) begin bus.PSLVERR_S0 = err; bus.PRDATA_S0 = data; end
        end else if (target == 1) begin
            bus.PREADY_S1 = ready;
            if (ready) begin bus.PSLVERR_S1 = err; bus.PRDATA_S1 = data; end
        end
    endtask

    // One complete command/response exchange; records what happened into obs_*.
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot, input int waits,
                          input logic slverr, input logic [31:0] rdata, input int hold);
        int target;
        int acc;
        logic [3:0] exp_strb;
        target = decode(addr);
        exp_strb = wr ? strb : 4'b0000;
        acc = 0;
        obs_seen = 0; obs_release_ok = 0; obs_rsp_cycle = -1;
        obs_psel0 = 0; obs_psel1 = 0; obs_penable = 0; obs_apb_bad = 0; obs_hold_bad = 0;
        obs_err = 1'bx; obs_rdata = 'x;
        @(negedge PCLK);
        obs_ready_at_issue = bus.cmd_ready;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_strb  = strb;
        bus.cmd_prot  = prot;
        bus.rsp_ready = 1'b0;
        set_slaves(target, 1'b0, slverr, rdata);
        for (int k = 1; k <= 60; k++) begin
            @(negedge PCLK);
            if (k == 1) begin
                bus.cmd_valid = 1'b0;
                bus.cmd_write = 1'($urandom);
                bus.cmd_addr  = $urandom;
                bus.cmd_wdata = $urandom;
                bus.cmd_strb  = 4'($urandom);
                bus.cmd_prot  = 3'($urandom);
            end
            if (bus.PSEL_S0) obs_psel0++;
            if (bus.PSEL_S1) obs_psel1++;
            if ((bus.PSEL_S0 || bus.PSEL_S1) && (bus.PADDR !== addr || bus.PWDATA !== wdata ||
                bus.PWRITE !== wr || bus.PPROT !== prot || bus.PSTRB !== exp_strb)) obs_apb_bad++;
            if (bus.PENABLE) acc++;
            obs_penable = acc;
            if (bus.rsp_valid === 1'b1) begin
                obs_seen = 1; obs_rsp_cycle = k; obs_err = bus.rsp_err; obs_rdata = bus.rsp_rdata;
            end
            set_slaves(target, bus.PENABLE && (waits >= 0) && (acc > waits), slverr, rdata);
            if (obs_seen) break;
        end
        if (obs_seen) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge PCLK);
                if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== obs_err || bus.rsp_rdata !== obs_rdata ||
                    bus.cmd_ready !== 1'b0 || bus.PSEL_S0 || bus.PSEL_S1) obs_hold_bad++;
            end
            bus.rsp_ready = 1'b1;
            @(negedge PCLK);
            bus.rsp_ready = 1'b0;
            obs_release_ok = (bus.rsp_valid === 1'b0) && (bus.cmd_ready === 1'b1);
        end
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        checks++;
        if ({bus.PSEL_S0, bus.PSEL_S1, bus.PENABLE, bus.PWRITE, bus.PPROT, bus.PSTRB} !== 10'b0 || bus.PADDR !== 32'h0 || bus.PWDATA !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_apb: PSEL=%b%b PENABLE=%b PADDR=%h PWDATA=%h PSTRB=%h, required all zero", bus.PSEL_S1, bus.PSEL_S0, bus.PENABLE, bus.PADDR, bus.PWDATA, bus.PSTRB);
        end
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_handshake: cmd_ready=%b rsp_valid=%b rsp_err=%b rsp_rdata=%h, required 1 0 0 0", bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
    endtask

    task automatic test_write();
        do_txn(1'b1, 32'h2004, 32'hDEAD_BEEF, 4'b0011, 3'b010, 0, 1'b0, $urandom, 0);
        checks++;
        if (!obs_seen || obs_rsp_cycle != 3) begin errors++; $display("[TB] FAIL write_latency: rsp_valid at cycle %0d, required 3", obs_rsp_cycle); end
        checks++;
        if (obs_psel1 != 2 || obs_psel0 != 0 || obs_penable != 1) begin errors++; $display("[TB] FAIL write_psel: PSEL_S1 %0d PSEL_S0 %0d PENABLE %0d cycles, required 2 0 1", obs_psel1, obs_psel0, obs_penable); end
        checks++;
        if (obs_apb_bad != 0) begin errors++; $display("[TB] FAIL write_apb_fields: %0d bad cycles, required 0 (PSTRB 0011)", obs_apb_bad); end
        checks++;
        if (obs_err !== 1'b0 || obs_rdata !== 32'h0) begin errors++; $display("[TB] FAIL write_rsp: err=%b rdata=%h, required 0 00000000", obs_err, obs_rdata); end
        checks++;
        if (!obs_ready_at_issue || !obs_release_ok) begin errors++; $display("[TB] FAIL write_handshake: ready_at_issue=%b release_ok=%b, required 1 1", obs_ready_at_issue, obs_release_ok); end
    endtask

    task automatic test_read_strobes();
        do_txn(1'b0, 32'h1010, $urandom, 4'hF, 3'b001, 0, 1'b0, 32'h1234_5678, 0);
        checks++;
        if (obs_apb_bad != 0 || obs_psel0 != 2 || obs_psel1 != 0) begin errors++; $display("[TB] FAIL read_apb: bad=%0d psel0=%0d psel1=%0d, required 0 2 0 (PSTRB 0)", obs_apb_bad, obs_psel0, obs_psel1); end
        checks++;
        if (obs_rdata !== 32'h1234_5678 || obs_err !== 1'b0 || obs_rsp_cycle != 3) begin errors++; $display("[TB] FAIL read_rsp: rdata=%h err=%b cycle=%0d, required 12345678 0 3", obs_rdata, obs_err, obs_rsp_cycle); end
    endtask

    task automatic test_wait_error();
        do_txn(1'b0, 32'h2ABC, $urandom, 4'h5, 3'b111, 3, 1'b1, 32'hCAFE_F00D, 0);
        checks++;
        if (obs_penable != 4 || obs_psel1 != 5 || obs_rsp_cycle != 6) begin errors++; $display("[TB] FAIL wait_cycles: penable=%0d psel1=%0d cycle=%0d, required 4 5 6", obs_penable, obs_psel1, obs_rsp_cycle); end
        checks++;
        if (obs_apb_bad != 0) begin errors++; $display("[TB] FAIL wait_paddr_stable: %0d bad cycles, required 0", obs_apb_bad); end
        checks++;
        if (obs_err !== 1'b1 || obs_rdata !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL wait_slverr: err=%b rdata=%h, required 1 cafef00d", obs_err, obs_rdata); end
    endtask

    task automatic test_timeout();
        do_txn(1'b0, 32'h1800, $urandom, 4'h0, 3'b000, -1, 1'b0, $urandom, 0);
        checks++;
        if (obs_penable != TIMEOUT - 1 || obs_rsp_cycle != TIMEOUT + 1) begin errors++; $display("[TB] FAIL timeout_cycles: penable=%0d cycle=%0d, required %0d %0d", obs_penable, obs_rsp_cycle, TIMEOUT - 1, TIMEOUT + 1); end
        checks++;
        if (obs_err !== 1'b1 || obs_rdata !== 32'h0) begin errors++; $display("[TB] FAIL timeout_rsp: err=%b rdata=%h, required 1 00000000", obs_err, obs_rdata); end
        // ready arriving on the final allowed ACCESS cycle beats the timeout
        do_txn(1'b0, 32'h1804, $urandom, 4'h0, 3'b000, TIMEOUT - 2, 1'b0, 32'h5A5A_0001, 0);
        checks++;
        if (obs_penable != TIMEOUT - 1 || obs_err !== 1'b0 || obs_rdata !== 32'h5A5A_0001) begin errors++; $display("[TB] FAIL timeout_edge: penable=%0d err=%b rdata=%h, required %0d 0 5a5a0001", obs_penable, obs_err, obs_rdata, TIMEOUT - 1); end
    endtask

    task automatic test_decode_miss();
        do_txn(1'b0, 32'h3000, $urandom, 4'hF, 3'b000, 0, 1'b0, $urandom, 5);
        checks++;
        if (obs_psel0 != 0 || obs_psel1 != 0 || obs_rsp_cycle != 1) begin errors++; $display("[TB] FAIL miss_nosel: psel0=%0d psel1=%0d cycle=%0d, required 0 0 1", obs_psel0, obs_psel1, obs_rsp_cycle); end
        checks++;
        if (obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_hold_bad != 0 || !obs_release_ok) begin errors++; $display("[TB] FAIL miss_rsp: err=%b rdata=%h hold_bad=%0d release=%b, required 1 0 0 1", obs_err, obs_rdata, obs_hold_bad, obs_release_ok); end
        do_txn(1'b1, 32'h1FFF, 32'h0BAD_CAFE, 4'h8, 3'b100, 1, 1'b0, $urandom, 5);
        checks++;
        if (obs_psel0 != 3 || obs_psel1 != 0 || obs_err !== 1'b0 || obs_hold_bad != 0) begin errors++; $display("[TB] FAIL edge_hit: psel0=%0d psel1=%0d err=%b hold_bad=%0d, required 3 0 0 0", obs_psel0, obs_psel1, obs_err, obs_hold_bad); end
    endtask

    task automatic test_random();
        logic [31:0] edges [6];
        edges = '{32'h0FFF, 32'h1000, 32'h1FFF, 32'h2000, 32'h2FFF, 32'h3000};
        for (int n = 0; n < 40; n++) begin
            logic        wr;
            logic        serr;
            logic [31:0] addr;
            logic [31:0] rd;
            int          waits;
            int          tgt;
            int          acc;
            int          hold;
            logic        exp_err;
            logic [31:0] exp_rdata;
            int          exp_cycle;
            wr = 1'($urandom); serr = 1'($urandom); rd = $urandom;
            hold = $urandom_range(0, 3);
            case ($urandom_range(0, 4))
                0: addr = 32'h1000 + $urandom_range(0, 32'hFFF);
                1: addr = 32'h2000 + $urandom_range(0, 32'hFFF);
                2: addr = $urandom;
                default: addr = edges[$urandom_range(0, 5)];
            endcase
            case ($urandom_range(0, 9))
                0: waits = -1;
                1: waits = TIMEOUT - 2;
                default: waits = $urandom_range(0, 4);
            endcase
            do_txn(wr, addr, $urandom, 4'($urandom), 3'($urandom), waits, serr, rd, hold);
            tgt = decode(addr);
            acc = (tgt == 2) ? 0 : access_cycles(waits);
            exp_cycle = (tgt == 2) ? 1 : 2 + acc;
            exp_err   = (tgt == 2 || times_out(waits)) ? 1'b1 : serr;
            exp_rdata = (tgt == 2 || times_out(waits) || wr) ? 32'h0 : rd;
            checks++;
            if (!obs_seen || obs_rsp_cycle != exp_cycle || obs_penable != acc) begin errors++; $display("[TB] FAIL rand_timing #%0d addr=%h: cycle=%0d penable=%0d, required %0d %0d", n, addr, obs_rsp_cycle, obs_penable, exp_cycle, acc); end
            checks++;
            if (obs_psel0 != ((tgt == 0) ? acc + 1 : 0) || obs_psel1 != ((tgt == 1) ? acc + 1 : 0)) begin errors++; $display("[TB] FAIL rand_psel #%0d addr=%h: psel0=%0d psel1=%0d, target %0d with %0d access cycles", n, addr, obs_psel0, obs_psel1, tgt, acc); end
            checks++;
            if (obs_err !== exp_err || obs_rdata !== exp_rdata) begin errors++; $display("[TB] FAIL rand_rsp #%0d addr=%h: err=%b rdata=%h, required %b %h", n, addr, obs_err, obs_rdata, exp_err, exp_rdata); end
            checks++;
            if (obs_apb_bad != 0 || obs_hold_bad != 0 || !obs_ready_at_issue || !obs_release_ok) begin errors++; $display("[TB] FAIL rand_protocol #%0d: apb_bad=%0d hold_bad=%0d ready=%b release=%b, required 0 0 1 1", n, obs_apb_bad, obs_hold_bad, obs_ready_at_issue, obs_release_ok); end
        end
    endtask

    task automatic test_reset_mid_access();
        bit in_access;
        bit rsp_seen;
        in_access = 0;
        rsp_seen = 0;
        @(negedge PCLK);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'h1100;
        bus.cmd_wdata = 32'h7777_7777; bus.cmd_strb = 4'hF; bus.cmd_prot = 3'b011;
        set_slaves(0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 10 && !in_access; k++) begin
            @(negedge PCLK);
            bus.cmd_valid = 1'b0;
            set_slaves(0, 1'b0, 1'b0, 32'h0);
            if (bus.PENABLE === 1'b1) in_access = 1;
        end
        checks++;
        if (!in_access) begin errors++; $display("[TB] FAIL midreset_reach_access: PENABLE never seen, required within 10 cycles"); end
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        checks++;
        if ({bus.PSEL_S0, bus.PSEL_S1, bus.PENABLE, bus.PWRITE, bus.PPROT, bus.PSTRB} !== 10'b0 || bus.PADDR !== 32'h0 || bus.PWDATA !== 32'h0) begin
            errors++; $display("[TB] FAIL midreset_apb: PSEL=%b%b PENABLE=%b PWRITE=%b PADDR=%h PWDATA=%h PSTRB=%h, required all zero", bus.PSEL_S1, bus.PSEL_S0, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_handshake: rsp_valid=%b cmd_ready=%b, required 0 1", bus.rsp_valid, bus.cmd_ready); end
        repeat (4) begin
            @(negedge PCLK);
            set_slaves(0, 1'b1, 1'b1, 32'h0);
            if (bus.rsp_valid !== 1'b0) rsp_seen = 1;
        end
        checks++;
        if (rsp_seen) begin errors++; $display("[TB] FAIL midreset_no_rsp: response appeared after abort, required none"); end
    endtask

    // run every scenario in order, then report
    initial begin
        PRESET = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.cmd_strb = '0; bus.cmd_prot = '0; bus.rsp_ready = 1'b0;
        set_slaves(2, 1'b0, 1'b0, 32'h0);
        test_reset();
        test_write();
        test_read_strobes();
        test_wait_error();
        test_timeout();
        test_decode_miss();
        test_random();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
